id_ex_skid_stage: RTL
=====================

Name: id_ex_skid_stage

Overview:
ID/EX pipeline stage of the MIPS datapath. Sits directly downstream of decode and the immediate sign-extender. Registers one decoded instruction per cycle into the execute stage:
- PC+4, register operands, extended immediate, register indices, control word.
Uses a 2-entry skid buffer with valid/ready handshakes on both sides, so an execute-side stall never forms a combinational ready path back into decode.

Parameters:
DATA_W, 32, width of PC+4, rs/rt operands and extended immediate
CTRL_W, 10, width of packed control word (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0], Jump)
IDX_W, 5, register index width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  synchronous squash of all held entries (branch/jump taken)
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept; registered, depends only on internal state
in_pc4  in  DATA_W  PC+4 of instruction
in_rs  in  DATA_W  rs read data
in_rt  in  DATA_W  rt read data
in_imm  in  DATA_W  sign-extended immediate
in_rt_idx  in  IDX_W  rt index
in_rd_idx  in  IDX_W  rd index
in_ctrl  in  CTRL_W  control word
out_valid  out  1  execute-side entry valid
out_ready  in  1  execute stage consumes
out_pc4, out_rs, out_rt, out_imm, out_rt_idx, out_rd_idx, out_ctrl  out  same widths as inputs  registered payload

Behaviour:
- Reset (rst_n=0, async):
  - main_valid=0, skid_valid=0.
  - All payload registers = 0, so out_valid=0.
  - in_ready=1 while in reset and after release.
- Accept: in_fire = in_valid & in_ready.
- Deliver: out_fire = out_valid & out_ready.
- in_ready = !skid_valid. Zero combinational path from out_ready to in_ready.
- States (main_valid, skid_valid):
  - EMPTY (0,0)
  - ONE (1,0)
  - FULL (1,1)
- EMPTY:
  - in_fire -> ONE; payload loads into main. Latency in->out is 1 cycle.
- ONE:
  - in_fire & out_fire -> ONE; main reloads with new payload.
  - in_fire & !out_fire -> FULL; payload goes to skid.
  - !in_fire & out_fire -> EMPTY.
  - No event -> hold.
- FULL:
  - out_fire -> ONE; skid moves to main. in_ready=0, so no input is accepted.
  - No out_fire -> hold.
- Ordering: strict FIFO order; no entry is dropped or duplicated outside flush.
- Payload stability: out_* stay stable while out_valid=1 and out_ready=0.
- out_* are driven only from main registers.
- flush=1 (synchronous, highest priority):
  - Next state EMPTY. Any simultaneous in_fire is discarded.
  - Payload registers may keep stale data; out_valid=0 masks it.
  - in_ready=1 the cycle after flush.
- Reset mid-operation: immediate return to reset values regardless of state.
- No arithmetic in this stage; widths pass through unchanged.

Optional Feature:
Macro: IDEX_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt, 32 bits.
  - Increments each cycle out_valid=1 & out_ready=0; wraps 0xFFFFFFFF -> 0.
  - Cleared by reset only; flush does not clear it.
- Undefined:
  - Port and counter are absent.
  - Handshake behaviour is identical.

Decomposition:
- Package mips_pipe_pkg:
  - DATA_W, IDX_W, CTRL_W constants.
  - Control-bit position constants (CTRL_REGDST ... CTRL_JUMP).
  - Packed idex_payload_t typedef; PAYLOAD_W = 3*DATA_W + 2*IDX_W + CTRL_W + DATA_W.
- Sub-module skid_slot: one payload register + valid bit, with load/clear controls; instantiated twice (main, skid).
- Top holds state-transition logic and mux of in-payload vs skid-payload into main.

Test Plan:
- Reset with in_valid=1, out_ready=1 -> out_valid=0, in_ready=1 during reset; first in_imm=0xFFFF8000 appears on out_imm exactly 1 cycle after its in_fire.
- Stream 8 instructions (in_pc4=0x4,0x8,...,0x20), out_ready=1 constant -> 1 instruction per cycle, out_pc4 sequence identical, in_ready never drops.
- out_ready=0 for 3 cycles with in_valid=1 -> FULL after 2 accepts, in_ready=0 third cycle; on out_ready=1 both entries emerge in order with no loss; out_* stable while stalled.
- flush=1 in FULL state with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and concurrent entries never appear on output.
- Assert rst_n=0 asynchronously mid-FULL (between clock edges) -> out_valid drops immediately, all out_* = 0.
- With IDEX_STALL_CNT_EN: 5 stall cycles then flush then 2 stalls -> stall_cnt=7; preload to 0xFFFFFFFF via forced stalls -> wraps to 0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared widths, control-word bit positions, payload layout and stage state
// encoding for the MIPS ID/EX pipeline slice.
package mips_pipe_pkg;

   localparam int DATA_W = 32;
   localparam int IDX_W  = 5;
   localparam int CTRL_W = 10;

   localparam int CTRL_REGDST   = 9;
   localparam int CTRL_ALUSRC   = 8;
   localparam int CTRL_MEMTOREG = 7;
   localparam int CTRL_REGWRITE = 6;
   localparam int CTRL_MEMREAD  = 5;
   localparam int CTRL_MEMWRITE = 4;
   localparam int CTRL_BRANCH   = 3;
   localparam int CTRL_ALUOP_HI = 2;
   localparam int CTRL_ALUOP_LO = 1;
   localparam int CTRL_JUMP     = 0;

   localparam int PAYLOAD_W = 3*DATA_W + 2*IDX_W + CTRL_W + DATA_W;

   typedef struct packed {
      logic [DATA_W-1:0] pc4;
      logic [DATA_W-1:0] rs;
      logic [DATA_W-1:0] rt;
      logic [DATA_W-1:0] imm;
      logic [IDX_W-1:0]  rt_idx;
      logic [IDX_W-1:0]  rd_idx;
      logic [CTRL_W-1:0] ctrl;
   } idex_payload_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } idex_state_t;

endpackage

// File: rtl/id_ex_skid_stage_slot.sv
// skid_slot: one payload register with its valid bit. Clear wins over load and
// only drops the valid bit; the payload is left stale.
module skid_slot #(
   parameter int W = 148
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID/EX stage with a 2-entry skid buffer; in_ready comes only from the skid flop.
// Optional stall counter output enabled by defining IDEX_STALL_CNT_EN.
//
// state    | meaning
// ST_EMPTY | no entry held, out_valid=0
// ST_ONE   | main holds the head entry
// ST_FULL  | main holds head, skid holds the next entry, in_ready=0
module id_ex_skid_stage #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 10,
   parameter int IDX_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc4,
   input  logic [DATA_W-1:0] in_rs,
   input  logic [DATA_W-1:0] in_rt,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [IDX_W-1:0]  in_rt_idx,
   input  logic [IDX_W-1:0]  in_rd_idx,
   input  logic [CTRL_W-1:0] in_ctrl,
`ifdef IDEX_STALL_CNT_EN
   output logic [31:0]       stall_cnt,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc4,
   output logic [DATA_W-1:0] out_rs,
   output logic [DATA_W-1:0] out_rt,
   output logic [DATA_W-1:0] out_imm,
   output logic [IDX_W-1:0]  out_rt_idx,
   output logic [IDX_W-1:0]  out_rd_idx,
   output logic [CTRL_W-1:0] out_ctrl
);
   import mips_pipe_pkg::*;

   localparam int PW = 4*DATA_W + 2*IDX_W + CTRL_W;

   idex_state_t state, state_nxt;
   logic          in_fire, out_fire;
   logic          main_load, main_clr, main_sel_skid, skid_load, skid_clr;
   logic          main_valid, skid_valid;
   logic [PW-1:0] in_pl, main_d, main_q, skid_q;

   assign in_pl    = {in_pc4, in_rs, in_rt, in_imm, in_rt_idx, in_rd_idx, in_ctrl};
   assign in_ready = !skid_valid;
   assign out_valid = main_valid;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign main_d   = main_sel_skid ? skid_q : in_pl;
   assign {out_pc4, out_rs, out_rt, out_imm, out_rt_idx, out_rd_idx, out_ctrl} = main_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (in_fire) state_nxt = ST_ONE;
            ST_ONE: begin
               if (in_fire && !out_fire)      state_nxt = ST_FULL;
               else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (out_fire) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      main_load     = 1'b0;
      main_clr      = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clr      = 1'b0;
      if (flush) begin
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state)
            ST_EMPTY: main_load = in_fire;
            ST_ONE: begin
               if (in_fire && out_fire) main_load = 1'b1;
               else if (in_fire)        skid_load = 1'b1;
               else if (out_fire)       main_clr  = 1'b1;
            end
            ST_FULL: begin
               if (out_fire) begin
                  main_load     = 1'b1;
                  main_sel_skid = 1'b1;
                  skid_clr      = 1'b1;
               end
            end
            default: begin
               main_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

   skid_slot #(.W(PW)) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (main_load),
      .clear (main_clr),
      .d     (main_d),
      .valid (main_valid),
      .q     (main_q)
   );

   skid_slot #(.W(PW)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .clear (skid_clr),
      .d     (in_pl),
      .valid (skid_valid),
      .q     (skid_q)
   );

`ifdef IDEX_STALL_CNT_EN
   // Free-running wrap; only reset clears it, flush leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       stall_cnt <= '0;
      else if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule
